// File: rtl/mp_add_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer.
//   state_t : sequencer FSM states
//   idx_w() : word-index width for a given word count (never below 1 bit)
package mp_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/FA_Nbit.sv
// N-bit ripple adder word slice shared by the sequencer.
//   a, b : addend words
//   cin  : carry in
//   s    : sum word
//   cout : carry out of the top bit
module FA_Nbit #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer: one N-bit adder is stepped over
// WORDS words (LSW first) with the carry held in a register between words.
//   clk, rst   : clock, synchronous active-high reset
//   start      : request; only honoured in IDLE
//   sub, cin   : 1 = A-B, 0 = A+B+cin
//   a, b       : operands, captured when start is accepted
//   busy, done : busy in RUN/DONE; done pulses one cycle in DONE
//   sum, cout  : result (held until next accepted start) and carry / no-borrow
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           sub,
  input  logic           cin,
  input  logic [N*WORDS-1:0] a,
  input  logic [N*WORDS-1:0] b,
  output logic           busy,
  output logic           done,
  output logic [N*WORDS-1:0] sum,
  output logic           cout
);

  localparam int W     = N * WORDS;
  localparam int IDX_W = idx_w(WORDS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

  state_t           state, state_nx;
  logic [W-1:0]     op_a, op_b;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [N-1:0]     wa, wb, ws;
  logic             wc;

  assign wa = op_a[idx*N +: N];
  assign wb = op_b[idx*N +: N];

  FA_Nbit #(.N(N)) u_fa (
    .a    (wa),
    .b    (wb),
    .cin  (carry),
    .s    (ws),
    .cout (wc)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (idx == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      // busy/done are registered copies of the next state so they line up
      // with the state register itself.
      busy  <= (state_nx != IDLE);
      done  <= (state_nx == DONE);
      case (state)
        IDLE: if (start) begin
          op_a  <= a;
          // Subtraction as A + ~B + 1: the +1 rides in on the initial carry.
          op_b  <= sub ? ~b : b;
          carry <= sub ? 1'b1 : cin;
          idx   <= '0;
          sum   <= '0;
          cout  <= 1'b0;
        end
        RUN: begin
          sum[idx*N +: N] <= ws;
          carry           <= wc;
          if (idx == LAST) cout <= wc;
          else             idx  <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mp_add_seq.md
Name: mp_add_seq

Overview:
Multi-precision add/subtract sequencer. It computes a WORDS*N-bit sum or difference by time-multiplexing one N-bit adder (FA_Nbit) over successive words, LSW first. The carry is held in a register between words. It sits between a requesting datapath and the shared adder and owns all sequencing: operand capture, word indexing, carry chaining, completion signalling.

Parameters:
N, 4, width of one adder word in bits (>=1)
WORDS, 4, number of words per operand (>=1); total operand width W = N*WORDS

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  request new operation; sampled only in IDLE
sub  input  1  0 = A+B+cin, 1 = A-B (cin ignored)
cin  input  1  carry-in for add mode
a  input  W  operand A, captured on accepted start
b  input  W  operand B, captured on accepted start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse in DONE
sum  output  W  result register, holds until next accepted start
cout  output  1  final carry-out (add) / no-borrow flag (sub)

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high.
- Reset (any state, including mid-operation):
  - state=IDLE, idx=0, carry=0.
  - sum=0, cout=0, busy=0, done=0.
  - Captured operands are discarded; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> capture a into opA.
  - Capture b (sub=0) or ~b (sub=1) into opB.
  - carry <= (sub ? 1 : cin); idx <= 0; sum <= 0; cout <= 0; go to RUN.
  - start=0 -> stay in IDLE; outputs hold.
- RUN, each cycle:
  - The adder sees opA word[idx], opB word[idx] and carry.
  - sum word[idx] <= adder sum; carry <= adder cout.
  - If idx==WORDS-1: cout <= adder cout, go to DONE; else idx <= idx+1.
- DONE: done=1 for exactly one cycle, then IDLE. An accepted start in IDLE raises done exactly WORDS+1 cycles later.
- busy is registered, derived from state (state != IDLE).
- start while busy (RUN or DONE) is ignored; no queuing. Operand inputs may change freely after capture.
- Minimum start-to-start spacing: WORDS+2 cycles.
- Arithmetic: result is modulo 2^W.
  - Sub mode: cout=1 iff A>=B (unsigned); cout=0 means borrow.
- idx width: clog2(WORDS), minimum 1 bit.
- WORDS=1 must work: RUN lasts one cycle, then DONE.
- Partially written sum words are visible during RUN; sum is valid only when done=1 and after.

Decomposition:
- Shared package mp_add_pkg holds:
  - state enum typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - IDX_W function/constant derived from WORDS
- One sub-module: the existing FA_Nbit #(.N(N)) instance for the word add.
- Word select and sum-word write use indexed part-selects; no other sub-modules.

Test Plan:
1. N=4, WORDS=4, add: a=0xFFFF, b=0x0001, cin=0, start at cycle t -> busy from t+1, done at t+5, sum=0x0000, cout=1.
2. Add: a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0.
3. Sub: a=0x1000, b=0x0001 -> sum=0x0FFF, cout=1. Then sub: a=0x0000, b=0x0001 -> sum=0xFFFF, cout=0.
4. start re-asserted during RUN and DONE with different operands -> ignored, first result unchanged. Next start in IDLE is accepted.
5. rst asserted on the 2nd RUN cycle -> next cycle all outputs 0, state IDLE, no done pulse. A fresh start (0x00FF+0x0001) -> sum=0x0100.
6. WORDS=1, N=8: a=0xF0, b=0x20 -> done 2 cycles after start, sum=0x10, cout=1.
